divisor_programavel: RTL
========================

DIVISOR_PROGRAMAVEL -- requirements
Module: divisor_programavel

Interface
REQ-001 SHALL have parameter LARGURA, default 23, width of counter, divisor and free prescaler.
REQ-002 SHALL have parameter DIV_PADRAO, default 4194304, divide ratio applied at reset.
REQ-003 SHALL have parameter SEL_BIT, default 15, free-prescaler bit driven on sel (divide-by-65536 tap).
REQ-004 SHALL have port clock  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port habilita  input  1  count enable; low freezes all counters and outputs.
REQ-007 SHALL have port carrega  input  1  one-cycle strobe requesting a new divide ratio.
REQ-008 SHALL have port divisor  input  LARGURA  requested divide ratio, sampled when carrega=1.
REQ-009 SHALL have port pendente  output  1  high while a loaded ratio awaits application.
REQ-010 SHALL have port clock_reduzido  output  1  divided square wave.
REQ-011 SHALL have port tick  output  1  one-cycle pulse per divided period.
REQ-012 SHALL have port sel  output  1  fixed power-of-two tap of free prescaler.

Function
REQ-013 SHALL hold N_ef (active ratio), N_sombra (shadow), cnt (0..N_ef-1) and pre (free prescaler), all LARGURA bits.
REQ-014 SHALL, when habilita=1, increment cnt each cycle; when cnt=N_ef-1, wrap cnt to 0 (wrap event).
REQ-015 SHALL clamp any sampled divisor below 2 to 2.
REQ-016 SHALL, on carrega=1 without a wrap that cycle, store divisor in N_sombra and set pendente=1.
REQ-017 SHALL, on a wrap with pendente=1, copy N_sombra to N_ef and clear pendente.
REQ-018 SHALL, on carrega=1 coinciding with a wrap, load divisor directly into N_ef and leave pendente=0.
REQ-019 SHALL, on carrega while pendente=1, overwrite N_sombra (last request wins).
REQ-020 SHALL accept carrega regardless of habilita; application still waits for a wrap.
REQ-021 SHALL drive clock_reduzido=1 iff cnt >= ceil(N_ef/2), decoded from registers only; low half first, odd ratios have the extra cycle low.
REQ-022 SHALL register tick high for exactly the cycle following each wrap (latency 1), otherwise 0.
REQ-023 SHALL increment pre modulo 2^LARGURA each cycle habilita=1, and drive sel=pre[SEL_BIT] (period 2^(SEL_BIT+1)).
REQ-024 SHALL, when habilita=0, hold cnt, pre, clock_reduzido and sel, and drive tick=0.
REQ-025 SHALL have no combinational path from any input to any output.

Reset
REQ-026 SHALL, when reset=1 at a clock edge, set cnt=0, pre=0, N_ef=N_sombra=clamp(DIV_PADRAO), pendente=0, tick=0, clock_reduzido=0, sel=0.
REQ-027 SHALL give reset priority over carrega and habilita, discarding any pending ratio.
REQ-028 SHALL begin counting on the first enabled cycle after reset deasserts.

Structure
REQ-029 SHALL place the defaults LARGURA, DIV_PADRAO, SEL_BIT and the minimum ratio constant (2) in shared package divisor_pkg.
REQ-030 SHALL implement the free prescaler as sub-module contador_livre (parameter LARGURA; ports clock, reset, habilita, q).
REQ-031 SHALL fit in 120-400 lines of RTL.

Verification (LARGURA=8, DIV_PADRAO=6, SEL_BIT=2)
REQ-032 SHALL check reset: reset 1 for 2 cycles mid-count, then habilita=1 -> all outputs 0; clock_reduzido 000111 repeating; tick every 6th cycle, one cycle after cnt=5.
REQ-033 SHALL check deferred load: carrega with divisor=3 at cnt=2 -> pendente=1 until the wrap; the next period is 3 cycles, pattern 001.
REQ-034 SHALL check clamp and overlap: divisor=0, then divisor=1 with carrega while pendente=1 -> N_ef=2 after the wrap; clock_reduzido toggles every cycle and tick fires every 2 cycles.
REQ-035 SHALL check simultaneous load: carrega with divisor=5 on the cycle cnt=5 -> pendente stays 0; the next period is 5 cycles with pattern 00011.
REQ-036 SHALL check hold: habilita=0 for 4 cycles at cnt=4 -> cnt, sel and clock_reduzido frozen, tick=0; the count resumes from 4.
REQ-037 SHALL check the tap: 16 enabled cycles from reset -> sel 0 for 4 cycles, 1 for 4, repeating.

Source files
------------

// File: rtl/divisor_pkg.sv
// Shared defaults for the programmable clock divider and its free-running prescaler.
package divisor_pkg;

  localparam int LARGURA_PADRAO    = 23;
  localparam int DIV_PADRAO_PADRAO = 4194304;
  localparam int SEL_BIT_PADRAO    = 15;
  localparam int DIV_MINIMO        = 2;

  // A divide ratio below two cannot form a low and a high half.
  function automatic int limita_razao(input int valor);
    return (valor < DIV_MINIMO) ? DIV_MINIMO : valor;
  endfunction

endpackage

// File: rtl/divisor_programavel_contador_livre.sv
// Free-running prescaler: wraps modulo 2^LARGURA, advances only while enabled.
module contador_livre
  import divisor_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               habilita,
  output logic [LARGURA-1:0] q
);

  localparam logic [LARGURA-1:0] UM = LARGURA'(1);

  // Prescaler state with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (habilita) begin
      q <= q + UM;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/divisor_programavel.sv
// Programmable divider: shadowed ratio applied only at period boundaries,
// square-wave and tick outputs, plus a fixed power-of-two prescaler tap.
module divisor_programavel
  import divisor_pkg::*;
#(
  parameter int LARGURA    = LARGURA_PADRAO,
  parameter int DIV_PADRAO = DIV_PADRAO_PADRAO,
  parameter int SEL_BIT    = SEL_BIT_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               habilita,
  input  logic               carrega,
  input  logic [LARGURA-1:0] divisor,
  output logic               pendente,
  output logic               clock_reduzido,
  output logic               tick,
  output logic               sel
);

  localparam logic [LARGURA-1:0] MINIMO    = LARGURA'(DIV_MINIMO);
  localparam logic [LARGURA-1:0] DIV_RESET = LARGURA'(limita_razao(DIV_PADRAO));
  localparam logic [LARGURA-1:0] UM        = LARGURA'(1);

  logic [LARGURA-1:0] n_ef_r;
  logic [LARGURA-1:0] n_sombra_r;
  logic [LARGURA-1:0] cnt_r;
  logic [LARGURA-1:0] pre_s;
  logic [LARGURA-1:0] div_lim_s;
  logic [LARGURA-1:0] cnt_prox_s;
  logic [LARGURA-1:0] n_ef_prox_s;
  logic [LARGURA-1:0] metade_s;
  logic               wrap_s;
  logic               pre_unused_s;

  contador_livre #(
    .LARGURA (LARGURA)
  ) u_pre (
    .clock    (clock),
    .reset    (reset),
    .habilita (habilita),
    .q        (pre_s)
  );

  assign sel          = pre_s[SEL_BIT];
  // Only the tap bit leaves the block; the rest of the prescaler is internal.
  assign pre_unused_s = ^pre_s;

  // Next-state decode for the count, the active ratio and the high-half threshold.
  always_comb begin
    div_lim_s   = (divisor < MINIMO) ? MINIMO : divisor;
    wrap_s      = habilita && (cnt_r == (n_ef_r - UM));
    cnt_prox_s  = cnt_r;
    n_ef_prox_s = n_ef_r;
    if (habilita) begin
      cnt_prox_s = wrap_s ? '0 : (cnt_r + UM);
    end else begin
      cnt_prox_s = cnt_r;
    end
    if (wrap_s && carrega) begin
      n_ef_prox_s = div_lim_s;
    end else if (wrap_s && pendente) begin
      n_ef_prox_s = n_sombra_r;
    end else begin
      n_ef_prox_s = n_ef_r;
    end
    // ceil(N/2) without needing an extra bit for N+1.
    metade_s = (n_ef_prox_s >> 1) + {{(LARGURA-1){1'b0}}, n_ef_prox_s[0]};
  end

  // Divider state and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r          <= '0;
      n_ef_r         <= DIV_RESET;
      n_sombra_r     <= DIV_RESET;
      pendente       <= 1'b0;
      tick           <= 1'b0;
      clock_reduzido <= 1'b0;
    end else begin
      cnt_r          <= cnt_prox_s;
      n_ef_r         <= n_ef_prox_s;
      tick           <= wrap_s;
      clock_reduzido <= (cnt_prox_s >= metade_s);
      if (carrega && !wrap_s) begin
        n_sombra_r <= div_lim_s;
        pendente   <= 1'b1;
      end else if (wrap_s) begin
        n_sombra_r <= n_sombra_r;
        pendente   <= 1'b0;
      end else begin
        n_sombra_r <= n_sombra_r;
        pendente   <= pendente;
      end
    end
  end

endmodule
